// File: rtl/mem_access_initiator_pkg.sv
// Shared definitions for the memory access initiator.
//  - bus width defaults, read/write encoding of mem_rwb
//  - FSM state encoding
//  - width helper for the per-request retry counter
package mem_access_initiator_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_RETRY_DEF = 3;

  localparam logic RWB_WRITE = 1'b1;
  localparam logic RWB_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  // Bits needed to count 0..max_retry; never narrower than one bit.
  function automatic int retry_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/mem_access_initiator_if.sv
// Datapath-side request/response handshake plus memory-system bus.
//  master : the initiator (drives req_ready, resp_*, mem_rwb/mem_addr/mem_data)
//  slave  : the environment (datapath + memory system)
//  req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//  resp_valid/resp_rdata/resp_err                   : 1-cycle response, no backpressure
//  mem_rwb/mem_addr/mem_data/mem_rdata/mem_hit      : memory-system bus
interface mem_access_initiator_if
  import mem_access_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_rwb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_hit;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_hit,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rwb, mem_addr, mem_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_hit,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rwb, mem_addr, mem_data
  );

endinterface

// File: rtl/mem_access_initiator_req_fifo2.sv
// req_fifo2: 2-entry synchronous FIFO, slot 0 is always the head.
//  clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//  push, din      : write request; ignored while full, even if popping that cycle
//  pop            : drop the head; ignored while empty
//  head, head_next: oldest and second-oldest entry (head_next valid only when full)
//  full, empty    : occupancy flags
module req_fifo2 #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [W-1:0] head_next,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] slot;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      slot <= '0;
    end else begin
      unique case ({do_push, do_pop})
        // both at once only happens with exactly one entry: replace it
        2'b11: slot[0] <= din;
        2'b01: begin
          slot[0] <= slot[1];
          cnt     <= cnt - 2'd1;
        end
        2'b10: begin
          slot[cnt[0]] <= din;
          cnt          <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head      = slot[0];
  assign head_next = slot[1];

endmodule

// File: rtl/mem_access_initiator.sv
// mem_access_initiator: buffers load/store requests (2-deep) and issues them one
// at a time on the memory-system bus; loads stay on the bus through refill
// cycles until mem_hit or until MAX_RETRY misses have been absorbed.
//  clk, reset : rising-edge clock, synchronous active-high reset
//  bus        : mem_access_initiator_if.master (request, response, memory bus)
// Optional build macro MEM_STATS_EN adds saturating counters:
//  hit_cnt  : load hits seen in ISSUE
//  miss_cnt : load misses seen in ISSUE
//  err_cnt  : responses returned with resp_err
module mem_access_initiator
  import mem_access_initiator_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
`ifdef MEM_STATS_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_access_initiator_if.master  bus
`ifdef MEM_STATS_EN
  ,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt,
  output logic [CNT_W-1:0]        err_cnt
`endif
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int RW = retry_w(MAX_RETRY);

  state_t            state, state_d;
  logic [RW-1:0]     retry, retry_d;
  req_t              push_req, head, head_next, src;
  logic              full, empty, push, done, retry_max;
  logic              mem_rwb_d, resp_valid_d, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_d, resp_rdata_d;

  assign push_req      = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign bus.req_ready = ~full;
  assign push          = bus.req_valid & ~full;
  assign retry_max     = (retry == RW'(MAX_RETRY));
  // The head retires this cycle: store, load hit, or the miss that exhausts retries.
  assign done = (state == ST_ISSUE) &&
                (head.write == RWB_WRITE || bus.mem_hit || retry_max);

  req_fifo2 #(.W($bits(req_t))) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (done),
    .din       (push_req),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty)
  );

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      retry          <= '0;
      bus.mem_rwb    <= RWB_READ;
      bus.mem_addr   <= '0;
      bus.mem_data   <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= state_d;
      retry          <= retry_d;
      bus.mem_rwb    <= mem_rwb_d;
      bus.mem_addr   <= mem_addr_d;
      bus.mem_data   <= mem_data_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_rdata <= resp_rdata_d;
      bus.resp_err   <= resp_err_d;
    end
  end

  // Next state. A second entry already in the FIFO keeps ISSUE busy back to back;
  // an entry pushed in the same cycle is not visible yet, so that path goes via IDLE.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:   if (!empty) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = done ? (full ? ST_ISSUE : ST_IDLE) : ST_REFILL;
      ST_REFILL: state_d = ST_ISSUE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and retry counter
  always_comb begin
    src          = done ? head_next : head;
    mem_rwb_d    = RWB_READ;
    mem_addr_d   = bus.mem_addr;   // outside ISSUE the address is held, reads only
    mem_data_d   = bus.mem_data;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    retry_d      = retry;
    if (state_d == ST_ISSUE) begin
      mem_rwb_d  = src.write;
      mem_addr_d = src.addr;
      mem_data_d = src.wdata;
    end
    if (state == ST_ISSUE) begin
      if (done) begin
        resp_valid_d = 1'b1;
        retry_d      = '0;
        if (head.write != RWB_WRITE) begin
          if (bus.mem_hit) resp_rdata_d = bus.mem_rdata;
          else             resp_err_d   = 1'b1;
        end
      end else begin
        retry_d = retry + 1'b1;
      end
    end
  end

`ifdef MEM_STATS_EN
  logic issue_load;
  assign issue_load = (state == ST_ISSUE) && (head.write != RWB_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (issue_load && bus.mem_hit && ~&hit_cnt)   hit_cnt  <= hit_cnt + 1'b1;
      if (issue_load && !bus.mem_hit && ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
      if (resp_err_d && ~&err_cnt)                  err_cnt  <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
